// File: rtl/rr_grant_arbiter_if.sv
// rr_grant_arbiter_if: request/grant bundle between requesters and the round-robin arbiter
interface rr_grant_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     ack;
  logic [IDX_W-1:0] grant_idx;
  logic             busy;
  logic             forced;
  modport master (output req, done, input ack, grant_idx, busy, forced);
  modport slave  (input req, done, output ack, grant_idx, busy, forced);
endinterface

// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin one-hot grant with done/drop/hold-limit release
module rr_grant_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input logic           clock_i,
  input logic           reset_i,
  rr_grant_arbiter_if.slave bus
);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state_q, state_d;
  logic [N-1:0]     ack_q, ack_d;
  logic [IDX_W-1:0] idx_q, idx_d, ptr_q, ptr_d, sel, nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic             rel_done, rel_drop, rel_to;
  // descending scan so the lowest circular offset from ptr wins
  always_comb begin
    sel = ptr_q;
    for (int i = N - 1; i >= 0; i--)
      if (bus.req[IDX_W'((int'(ptr_q) + i) % N)]) sel = IDX_W'((int'(ptr_q) + i) % N);
  end
  assign nxt      = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
  assign rel_done = bus.done;
  assign rel_drop = !bus.req[idx_q];
  assign rel_to   = (MAX_HOLD != 0) && (cnt_q == HOLD_MAX);
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    if (state_q == IDLE) begin
      if (|bus.req) begin
        state_d = GRANT;
        ack_d   = N'(1) << sel;
        idx_d   = sel;
        cnt_d   = CW'(1);
      end
    end else if (rel_done || rel_drop || rel_to) begin
      state_d  = IDLE;
      ack_d    = '0;
      ptr_d    = nxt;
      cnt_d    = '0;
      forced_d = rel_to && !rel_done && !rel_drop;
    end else begin
      cnt_d = (MAX_HOLD != 0 && cnt_q != HOLD_MAX) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      idx_q    <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
    end
  end
  assign bus.ack       = ack_q;
  assign bus.grant_idx = idx_q;
  assign bus.busy      = |ack_q;
  assign bus.forced    = forced_q;
  a_onehot: assert property (@(posedge clock_i) $onehot0(ack_q));
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb_rr_grant_arbiter: scoreboard bench with a per-cycle behavioural arbiter model
module tb_rr_grant_arbiter;
  localparam int N  = 4;
  localparam int MH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  rr_grant_arbiter_if #(.N(N), .IDX_W(2)) bus ();
  rr_grant_arbiter #(.N(N), .MAX_HOLD(MH), .IDX_W(2)) dut (
    .clock_i(clk),
    .reset_i(rst_n),
    .bus(bus)
  );
  typedef struct packed {
    logic [N-1:0] ack;
    logic [1:0]   idx;
    logic         busy;
    logic         forced;
  } obs_t;
  obs_t exp_q[$];
  int passed = 0;
  int checks = 0;
  int owner = -1;
  int ptr = 0;
  int held = 0;
  int last = 0;
  bit frc = 1'b0;
  function automatic bit has(input logic [N-1:0] r, input int c);
    return ((r >> c) & 1) != 0;
  endfunction
  task automatic step(input logic [N-1:0] r, input logic d, input logic rn);
    obs_t e;
    bit   found;
    bit   to;
    @(negedge clk);
    bus.req = r;
    bus.done = d;
    rst_n = rn;
    if (!rn) begin
      owner = -1; ptr = 0; held = 0; last = 0; frc = 1'b0;
    end else if (owner < 0) begin
      frc = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && has(r, (ptr + k) % N)) begin
          found = 1'b1;
          owner = (ptr + k) % N;
          last = owner;
          held = 1;
        end
      end
    end else begin
      to = (MH != 0) && (held == MH);
      if (d || !has(r, owner) || to) begin
        frc = !d && has(r, owner) && to;
        ptr = (owner + 1) % N;
        owner = -1;
        held = 0;
      end else begin
        frc = 1'b0;
        if (held < MH) held++;
      end
    end
    e.ack = (owner < 0) ? '0 : N'(1 << owner);
    e.idx = 2'(last);
    e.busy = owner >= 0;
    e.forced = frc;
    exp_q.push_back(e);
  endtask
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{bus.ack, bus.grant_idx, bus.busy, bus.forced};
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs @%0t: got ack=%b idx=%0d busy=%b forced=%b, want ack=%b idx=%0d busy=%b forced=%b",
                      $time, a.ack, a.idx, a.busy, a.forced, e.ack, e.idx, e.busy, e.forced);
      end
    end
  end
  initial begin
    logic [N-1:0] r;
    bus.req = '0;
    bus.done = 1'b0;
    repeat (3) step(4'b1111, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    repeat (10) begin
      step(4'b1111, 1'b1, 1'b1);
      step(4'b1111, 1'b0, 1'b1);
    end
    repeat (8) begin
      step(4'b1010, 1'b1, 1'b1);
      step(4'b1010, 1'b0, 1'b1);
    end
    step(4'b0100, 1'b1, 1'b1);
    repeat (40) step(4'b0100, 1'b0, 1'b1);
    step(4'b0010, 1'b1, 1'b1);
    repeat (3) step(4'b0010, 1'b0, 1'b1);
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    repeat (5) step(4'b0100, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b1111, 1'b0, 1'b1);
    r = 4'b0000;
    repeat (800) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      step(r, $urandom_range(5) == 0, $urandom_range(59) != 0);
    end
    repeat (2) step(4'b0000, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
